synth_output_harness: RTL and testbench
=======================================

SYNTH_OUTPUT_HARNESS -- requirements
Module: synth_output_harness

Interface
REQ-001 Parameter WIDTH, default 354: width of the parallel DUT output vector to serialise.
REQ-002 Parameter CNT_W, default $clog2(WIDTH): width of the bit counter.
REQ-003 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 dut_out  in  WIDTH  parallel outputs of the DUT under LUT measurement.
REQ-007 capture  in  1  request to snapshot dut_out.
REQ-008 ser_ready  in  1  downstream pin-side sink accepts ser_out this cycle.
REQ-009 ser_out  out  1  current serial bit, LSB first.
REQ-010 ser_valid  out  1  ser_out holds a valid bit.
REQ-011 busy  out  1  a snapshot is being shifted out.
REQ-012 done  out  1  one-cycle pulse after the final bit transfers.
REQ-013 parity  out  1  XOR of all bits of the last completed snapshot.

Function
REQ-014 The FSM SHALL have two states: IDLE and SHIFT.
REQ-015 In IDLE, with capture=1, the block SHALL load dut_out into shreg, clear cnt and par_acc, and enter SHIFT.
REQ-016 In IDLE, with capture=0, the block SHALL hold all state.
REQ-017 In SHIFT, capture SHALL be ignored, and dut_out SHALL NOT be resampled.
REQ-018 The block SHALL drive ser_valid = (state==SHIFT) and busy = (state==SHIFT), both registered-state decodes.
REQ-019 The block SHALL drive ser_out = shreg[0] when ser_valid=1, and 0 otherwise.
REQ-020 A transfer SHALL occur only on cycles with ser_valid=1 and ser_ready=1.
- On a transfer: shift shreg right by one, set par_acc ^= shreg[0], and increment cnt.
REQ-021 With ser_ready=0 in SHIFT, shreg, cnt and par_acc SHALL hold, and ser_out SHALL stay stable.
REQ-022 On a transfer with cnt==WIDTH-1, the block SHALL return to IDLE, pulse done for exactly the next cycle, and load parity with the final par_acc value (including the last bit).
REQ-023 The parity output SHALL hold its value until the next completed snapshot; a new capture SHALL NOT clear it.
REQ-024 Latency with ser_ready held high: capture accepted in cycle N gives:
- ser_valid first high in cycle N+1;
- last bit transferred in cycle N+WIDTH;
- done=1 and busy=0 in cycle N+WIDTH+1.
REQ-025 A capture in the same cycle as the final transfer SHALL be ignored, because busy is still 1 in that cycle; the earliest accepted re-capture is in the done cycle.
REQ-026 cnt SHALL never exceed WIDTH-1; no wrap-around SHALL be reachable.
REQ-027 WIDTH=1 SHALL work: a single transfer completes the snapshot.

Reset
REQ-028 When RST=1 at a clock edge, the block SHALL set state=IDLE, and shreg, cnt, par_acc, parity and done to 0, regardless of capture or a transfer in progress.
REQ-029 During and after reset, ser_out, ser_valid, busy, done and parity SHALL all read 0 until the first capture.
REQ-030 Reset mid-SHIFT SHALL abort the snapshot without a done pulse, and parity SHALL read 0.

Structure
REQ-031 Package harness_pkg SHALL hold HARNESS_OUT_WIDTH=354, HARNESS_IN_WIDTH=365 and the state enum (IDLE, SHIFT).
- The block SHALL be instantiated with WIDTH=HARNESS_OUT_WIDTH alongside the null/real UnifiedSingleExposerKeyMngrTb.
REQ-032 The block SHALL be a single module with no sub-module; the FSM, counter and shift register are small enough to be inline.
REQ-033 The block SHALL contain no combinational path from dut_out to any output.

Verification
REQ-034 WIDTH=8, dut_out=8'hA5, capture pulse, ser_ready=1 -> ser_out sequence 1,0,1,0,0,1,0,1 in cycles N+1..N+8; done pulse at N+9; parity=0.
REQ-035 WIDTH=8, dut_out=8'h07, ser_ready toggling 1,0,1,0... -> same bit order with each bit held while ready=0; done after exactly 8 transfers; parity=1.
REQ-036 WIDTH=8, capture held high continuously, dut_out changing every cycle -> second snapshot loads only in the done cycle and contains the dut_out value from that cycle.
REQ-037 WIDTH=8, RST asserted after 3 transfers -> next cycle all outputs 0, no done pulse; a fresh capture then works normally.
REQ-038 WIDTH=354, random dut_out, ready=1 -> 354 serial bits equal dut_out LSB-first; done at N+355; parity = reduction-XOR of dut_out.
REQ-039 WIDTH=1, dut_out=1, capture -> ser_valid for one cycle, done next cycle, parity=1.

Source files
------------

// File: rtl/synth_output_harness_pkg.sv
// Shared constants and state encoding for the LUT-measurement output harness.
package harness_pkg;

    // Widths of the measured DUT's parallel output and input vectors.
    localparam int HARNESS_OUT_WIDTH = 354;
    localparam int HARNESS_IN_WIDTH  = 365;

    // Serialiser states: waiting for a capture, or shifting a snapshot out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage : harness_pkg

// File: rtl/synth_output_harness_if.sv
// Bundle of the snapshot/serial signals between the harness and its surroundings.
interface synth_output_harness_if
    import harness_pkg::*;
#(
    parameter int WIDTH = HARNESS_OUT_WIDTH
);

    logic [WIDTH-1:0] dut_out;    // parallel outputs of the measured DUT
    logic             capture;    // request to snapshot dut_out
    logic             ser_ready;  // pin-side sink accepts ser_out this cycle
    logic             ser_out;    // current serial bit, LSB first
    logic             ser_valid;  // ser_out holds a valid bit
    logic             busy;       // a snapshot is being shifted out
    logic             done;       // one-cycle pulse after the final bit transfers
    logic             parity;     // XOR of all bits of the last completed snapshot

    // Environment side: supplies the vector and the handshakes, observes the stream.
    modport master (
        output dut_out, capture, ser_ready,
        input  ser_out, ser_valid, busy, done, parity
    );

    // Harness side: snapshots the vector and drives the serial stream.
    modport slave (
        input  dut_out, capture, ser_ready,
        output ser_out, ser_valid, busy, done, parity
    );

endinterface : synth_output_harness_if

// File: rtl/synth_output_harness.sv
// Snapshots a wide DUT output vector and shifts it out LSB first over a
// valid/ready serial pin, reporting the XOR parity of each completed snapshot.
// Every output is decoded from registered state, so dut_out never reaches a pin
// combinationally and the measured logic cannot be optimised through the harness.
module synth_output_harness
    import harness_pkg::*;
#(
    parameter int WIDTH = HARNESS_OUT_WIDTH,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    synth_output_harness_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             par_acc_q;
    logic             parity_q;
    logic             done_q;

    logic [WIDTH-1:0] shreg_d;
    logic             par_acc_d;
    logic             xfer;
    logic             last_xfer;

    assign xfer      = (state_q == SHIFT) && bus.ser_ready;
    assign last_xfer = xfer && (cnt_q == LAST_IDX);
    assign shreg_d   = shreg_q >> 1;
    assign par_acc_d = par_acc_q ^ shreg_q[0];

    // FSM, bit counter, shift register and parity tracking in one registered process.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the shift register is cleared on reset because ser_out is
            // decoded from shreg_q[0] and must read 0 straight out of reset.
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            par_acc_q <= 1'b0;
            parity_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: default-low assignment makes done a single-cycle pulse; all
            // state uses non-blocking assignment so every read sees the old value.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.capture) begin
                        shreg_q   <= bus.dut_out;
                        cnt_q     <= '0;
                        par_acc_q <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        shreg_q   <= shreg_d;
                        par_acc_q <= par_acc_d;
                        if (last_xfer) begin
                            // Counter parks at 0 so it can never pass LAST_IDX.
                            cnt_q    <= '0;
                            parity_q <= par_acc_d;
                            done_q   <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ser_valid = (state_q == SHIFT);
    assign bus.busy      = (state_q == SHIFT);
    assign bus.ser_out   = (state_q == SHIFT) ? shreg_q[0] : 1'b0;
    assign bus.done      = done_q;
    assign bus.parity    = parity_q;

endmodule : synth_output_harness

// File: tb/tb_synth_output_harness.sv
// Directed bench for synth_output_harness at WIDTH = 8, 354 and 1.
// Stimulus pushes the expected serial bits and parities into per-instance
// queues; negedge monitors pop and compare whenever a transfer or done occurs.
module tb_synth_output_harness;

    logic clk;
    logic rst;

    int tests;
    int fails;

    bit bits8_q[$];
    bit par8_q[$];
    bit bits354_q[$];
    bit par354_q[$];
    bit bits1_q[$];
    bit par1_q[$];

    synth_output_harness_if #(.WIDTH(8))   if8   ();
    synth_output_harness_if #(.WIDTH(354)) if354 ();
    synth_output_harness_if #(.WIDTH(1))   if1   ();

    synth_output_harness #(.WIDTH(8))   u8   (.CLK(clk), .RST(rst), .bus(if8));
    synth_output_harness #(.WIDTH(354)) u354 (.CLK(clk), .RST(rst), .bus(if354));
    synth_output_harness #(.WIDTH(1))   u1   (.CLK(clk), .RST(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input logic [7:0] v, input bit p);
        for (int i = 0; i < 8; i++) bits8_q.push_back(v[i]);
        par8_q.push_back(p);
    endtask

    // Called in cycle N+1 of a WIDTH=8 snapshot; measures the cycle of done.
    task automatic wait_done8(input int exp_cyc, input string name);
        int n;
        n = 1;
        @(negedge clk);
        check({name, "_first_valid"}, if8.ser_valid, 1'b1);
        while (!if8.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, n, exp_cyc);
        check({name, "_busy_at_done"}, if8.busy, 1'b0);
    endtask

    // Scoreboard monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (if8.ser_valid && if8.ser_ready) begin
                if (bits8_q.size() == 0) check("w8_unexpected_xfer", 1, 0);
                else check("w8_bit", if8.ser_out, bits8_q.pop_front());
            end else if (if8.ser_valid && bits8_q.size() > 0) begin
                check("w8_hold", if8.ser_out, bits8_q[0]);
            end
            if (if8.done) begin
                if (par8_q.size() == 0) check("w8_unexpected_done", 1, 0);
                else check("w8_parity", if8.parity, par8_q.pop_front());
            end
        end
    end

    // Scoreboard monitor for the WIDTH=354 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (if354.ser_valid && if354.ser_ready) begin
                if (bits354_q.size() == 0) check("w354_unexpected_xfer", 1, 0);
                else check("w354_bit", if354.ser_out, bits354_q.pop_front());
            end
            if (if354.done) begin
                if (par354_q.size() == 0) check("w354_unexpected_done", 1, 0);
                else check("w354_parity", if354.parity, par354_q.pop_front());
            end
        end
    end

    // Scoreboard monitor for the WIDTH=1 instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (if1.ser_valid && if1.ser_ready) begin
                if (bits1_q.size() == 0) check("w1_unexpected_xfer", 1, 0);
                else check("w1_bit", if1.ser_out, bits1_q.pop_front());
            end
            if (if1.done) begin
                if (par1_q.size() == 0) check("w1_unexpected_done", 1, 0);
                else check("w1_parity", if1.parity, par1_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [353:0] vec;
        int n;
        tests = 0;
        fails = 0;

        rst = 1'b1;
        if8.dut_out = '0;   if8.capture = 1'b0;   if8.ser_ready = 1'b1;
        if354.dut_out = '0; if354.capture = 1'b0; if354.ser_ready = 1'b1;
        if1.dut_out = '0;   if1.capture = 1'b0;   if1.ser_ready = 1'b1;
        repeat (3) tick();

        // Reset state on all instances.
        @(negedge clk);
        check("rst_w8_outs", {if8.ser_out, if8.ser_valid, if8.busy, if8.done, if8.parity}, 5'b0);
        check("rst_w354_outs", {if354.ser_out, if354.ser_valid, if354.busy, if354.done, if354.parity}, 5'b0);
        check("rst_w1_outs", {if1.ser_out, if1.ser_valid, if1.busy, if1.done, if1.parity}, 5'b0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle_w8", {if8.ser_out, if8.ser_valid, if8.busy, if8.done, if8.parity}, 5'b0);

        // A5 with ready high: bits 1,0,1,0,0,1,0,1, done at N+9, parity 0.
        if8.dut_out = 8'hA5; if8.capture = 1'b1;
        push8(8'hA5, 1'b0);
        tick();
        if8.capture = 1'b0; if8.dut_out = 8'h00;
        wait_done8(9, "w8_a5");

        // 07 with ready toggling 1,0,1,0...: 8 transfers over 15 cycles, done at N+16, parity 1.
        tick();
        if8.dut_out = 8'h07; if8.capture = 1'b1;
        push8(8'h07, 1'b1);
        tick();
        if8.capture = 1'b0; if8.ser_ready = 1'b1;
        n = 1;
        forever begin
            @(negedge clk);
            if (if8.done || n >= 100) break;
            tick();
            n++;
            if8.ser_ready = n[0];
        end
        check("w8_07_toggle_latency", n, 16);
        if8.ser_ready = 1'b1;

        // Capture held high while dut_out changes each cycle: second snapshot
        // is the cycle-9 value 8'h45 (the cycle-8 value 8'h44 must be ignored).
        tick();
        if8.dut_out = 8'h3C; if8.capture = 1'b1;
        push8(8'h3C, 1'b0);
        push8(8'h45, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if8.dut_out = 8'h3C + 8'(k);
        end
        @(negedge clk);
        check("w8_recap_done_cycle", if8.done, 1'b1);
        tick();
        if8.capture = 1'b0; if8.dut_out = 8'h00;
        wait_done8(9, "w8_recap");

        // Reset after 3 transfers of C3 (bits 1,1,0): outputs clear, no done.
        tick();
        if8.dut_out = 8'hC3; if8.capture = 1'b1;
        bits8_q.push_back(1'b1);
        bits8_q.push_back(1'b1);
        bits8_q.push_back(1'b0);
        tick();
        if8.capture = 1'b0;
        repeat (2) tick();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("w8_midrst_outs", {if8.ser_out, if8.ser_valid, if8.busy, if8.done, if8.parity}, 5'b0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("w8_midrst_no_done", {if8.busy, if8.done, if8.parity}, 3'b0);

        // Fresh capture after reset: 58 -> parity 1.
        tick();
        if8.dut_out = 8'h58; if8.capture = 1'b1;
        push8(8'h58, 1'b1);
        tick();
        if8.capture = 1'b0;
        wait_done8(9, "w8_58");

        // Full width random vector: done at N+355, parity = ^vec.
        for (int i = 0; i < 354; i++) vec[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 354; i++) bits354_q.push_back(vec[i]);
        par354_q.push_back(^vec);
        tick();
        if354.dut_out = vec; if354.capture = 1'b1;
        tick();
        if354.capture = 1'b0; if354.dut_out = '0;
        n = 1;
        @(negedge clk);
        check("w354_first_valid", if354.ser_valid, 1'b1);
        while (!if354.done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("w354_latency", n, 355);
        check("w354_busy_at_done", if354.busy, 1'b0);

        // WIDTH=1: one valid cycle, done the next, parity 1.
        tick();
        if1.dut_out = 1'b1; if1.capture = 1'b1;
        bits1_q.push_back(1'b1);
        par1_q.push_back(1'b1);
        tick();
        if1.capture = 1'b0; if1.dut_out = 1'b0;
        @(negedge clk);
        check("w1_valid_n1", {if1.ser_valid, if1.done}, 2'b10);
        @(negedge clk);
        check("w1_done_n2", {if1.ser_valid, if1.busy, if1.done}, 3'b001);
        @(negedge clk);
        check("w1_parity_held", {if1.done, if1.parity}, 2'b01);

        repeat (2) tick();
        check("w8_queue_drained", bits8_q.size() + par8_q.size(), 0);
        check("w354_queue_drained", bits354_q.size() + par354_q.size(), 0);
        check("w1_queue_drained", bits1_q.size() + par1_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_synth_output_harness
